// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_pkg : widths, block/byte types and serializer states for AES datapath  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_NBYTES  = AES_BLOCK_W / AES_BYTE_W;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;
  typedef logic [AES_BYTE_W-1:0]  aes_byte_t;

  typedef enum logic [0:0] {
    SER_EMPTY = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

endpackage
`default_nettype wire

// File: rtl/aes_block_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_block_serializer : streams 128-bit blocks out MSB byte first, with a   |
// | one-block hold buffer so back-to-back blocks drain without gaps.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module aes_block_serializer
  import aes_pkg::*;
#(
  parameter int BLOCK_W = AES_BLOCK_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               blk_valid,
  input  logic [BLOCK_W-1:0] blk_data,
  output logic               blk_ready,
  output logic [7:0]         byte_out,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic               byte_last,
  output logic               busy
);

  localparam int              NBYTES   = BLOCK_W / AES_BYTE_W;
  localparam int              IDX_W    = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  ser_state_e         state_q, state_d;
  logic [BLOCK_W-1:0] sh_q, sh_d;
  logic [BLOCK_W-1:0] hd_q, hd_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               hd_full_q, hd_full_d;
  logic               live_q, live_d;

  logic sh_full;
  logic xfer;
  logic last_xfer;
  logic accept;

  always_comb begin
    sh_full   = (state_q == SER_SHIFT);
    xfer      = sh_full && byte_ready;
    last_xfer = xfer && (idx_q == LAST_IDX);
    accept    = blk_valid && blk_ready;

    state_d   = state_q;
    sh_d      = sh_q;
    hd_d      = hd_q;
    idx_d     = idx_q;
    hd_full_d = hd_full_q;
    live_d    = 1'b1;

    if (xfer) begin
      if (last_xfer) begin
        idx_d = '0;
        if (hd_full_q) begin
          sh_d      = hd_q;
          hd_full_d = 1'b0;
        end else if (accept) begin
          sh_d = blk_data;
        end else begin
          state_d = SER_EMPTY;
        end
      end else begin
        sh_d  = sh_q << AES_BYTE_W;
        idx_d = idx_q + 1'b1;
      end
    end

    // accept implies an empty hold buffer, so a reload from hd never collides here
    if (accept && !last_xfer) begin
      if (!sh_full) begin
        sh_d    = blk_data;
        state_d = SER_SHIFT;
        idx_d   = '0;
      end else begin
        hd_d      = blk_data;
        hd_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= SER_EMPTY;
      sh_q      <= '0;
      hd_q      <= '0;
      idx_q     <= '0;
      hd_full_q <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      hd_q      <= hd_d;
      idx_q     <= idx_d;
      hd_full_q <= hd_full_d;
      live_q    <= live_d;
    end
  end

  assign blk_ready  = live_q && !hd_full_q;
  assign byte_out   = sh_q[BLOCK_W-1 -: 8];
  assign byte_valid = sh_full;
  assign byte_last  = sh_full && (idx_q == LAST_IDX);
  assign busy       = sh_full || hd_full_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_block_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_aes_block_serializer : directed vectors and sequences for the serializer|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_aes_block_serializer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         blk_valid = 1'b0;
  logic [127:0] blk_data = 128'd0;
  logic         byte_ready = 1'b0;
  logic         blk_ready;
  logic [7:0]   byte_out;
  logic         byte_valid;
  logic         byte_last;
  logic         busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aes_block_serializer #(.BLOCK_W(128)) dut (
    .clk        (clk),
    .rst        (rst),
    .blk_valid  (blk_valid),
    .blk_data   (blk_data),
    .blk_ready  (blk_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_last  (byte_last),
    .busy       (busy)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic         rst_n;
    logic         v;
    logic [127:0] d;
    logic         br;
    logic         e_bv;
    logic [7:0]   e_byte;
    logic         chk_byte;
    logic         e_last;
    logic         e_rdy;
    logic         e_busy;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  logic [127:0] sb;
  logic [127:0] blocks[3];
  logic [7:0]   exp_stream[48];
  logic [7:0]   b_bytes[16];
  logic [7:0]   ct_bytes[16];

  initial begin
    logic [7:0] exp_k;
    int         k;
    int         nb;
    int         nxt;
    int         seen;
    logic       acc;
    logic       rdy16;
    int         got_cyc[48];
    int         acc_cyc[3];

    sb        = 128'h00112233445566778899aabbccddeeff;
    blocks[0] = 128'h0f0e0d0c0b0a09080706050403020100;
    blocks[1] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    blocks[2] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    b_bytes   = '{8'h3a, 8'hd7, 8'h7b, 8'hb4, 8'h0d, 8'h7a, 8'h36, 8'h60,
                  8'ha8, 8'h9e, 8'hca, 8'hf3, 8'h24, 8'h66, 8'hef, 8'h97};
    ct_bytes  = '{8'h69, 8'hc4, 8'he0, 8'hd8, 8'h6a, 8'h7b, 8'h04, 8'h30,
                  8'hd8, 8'hcd, 8'hb7, 8'h80, 8'h70, 8'hb4, 8'hc5, 8'h5a};
    for (int i = 0; i < 16; i++) begin
      exp_stream[i]      = 8'(15 - i);
      exp_stream[16 + i] = b_bytes[i];
      exp_stream[32 + i] = ct_bytes[i];
    end

    // Reset with blk_valid high, release, then one block at full rate
    for (int i = 0; i < 3; i++)
      vecs[i] = '{1'b0, 1'b1, sb, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, sb, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, sb, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 1; i < 16; i++)
      vecs[4 + i] = '{1'b1, 1'b0, 128'd0, 1'b1, 1'b1, 8'(17 * i), 1'b1, (i == 15), 1'b1, 1'b1};
    vecs[20] = '{1'b1, 1'b0, 128'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < NV; i++) begin
      rst        = vecs[i].rst_n;
      blk_valid  = vecs[i].v;
      blk_data   = vecs[i].d;
      byte_ready = vecs[i].br;
      @(negedge clk);
      chk1($sformatf("v%0d byte_valid", i), byte_valid, vecs[i].e_bv);
      chk1($sformatf("v%0d byte_last", i), byte_last, vecs[i].e_last);
      chk1($sformatf("v%0d blk_ready", i), blk_ready, vecs[i].e_rdy);
      chk1($sformatf("v%0d busy", i), busy, vecs[i].e_busy);
      if (vecs[i].chk_byte)
        chk8($sformatf("v%0d byte_out", i), byte_out, vecs[i].e_byte);
    end

    // Backpressure: ready on even cycles only, 31 cycles to drain
    blk_valid  = 1'b1;
    blk_data   = sb;
    byte_ready = 1'b0;
    @(negedge clk);
    blk_valid = 1'b0;
    blk_data  = 128'd0;
    k = 0;
    for (int c = 0; c < 31; c++) begin
      byte_ready = (c % 2 == 0);
      exp_k = 8'(17 * k);
      chk1($sformatf("bp c%0d byte_valid", c), byte_valid, 1'b1);
      chk8($sformatf("bp c%0d byte_out", c), byte_out, exp_k);
      chk1($sformatf("bp c%0d byte_last", c), byte_last, (k == 15));
      @(negedge clk);
      if (byte_ready) k++;
    end
    byte_ready = 1'b1;
    chk1("bp drained byte_valid", byte_valid, 1'b0);
    chk1("bp drained busy", busy, 1'b0);

    // Back-to-back three blocks; data garbled whenever it cannot be taken
    nb = 0;
    nxt = 0;
    rdy16 = 1'bx;
    acc_cyc = '{-1, -1, -1};
    blk_valid = 1'b1;
    for (int c = 0; c < 54; c++) begin
      if (nxt < 3)
        blk_data = blk_ready ? blocks[nxt] : {$urandom, $urandom, $urandom, $urandom};
      acc = blk_valid && blk_ready;
      if (acc) acc_cyc[nxt] = c;
      if (c == 16) rdy16 = blk_ready;
      if (byte_valid && nb < 48) begin
        chk8($sformatf("b2b byte %0d", nb), byte_out, exp_stream[nb]);
        chk1($sformatf("b2b last %0d", nb), byte_last, (nb % 16 == 15));
        got_cyc[nb] = c;
        nb++;
      end
      @(negedge clk);
      if (acc) begin
        nxt++;
        if (nxt == 3) blk_valid = 1'b0;
      end
    end
    chki("b2b bytes seen", nb, 48);
    if (nb == 48) begin
      chki("b2b first byte cycle", got_cyc[0], 1);
      chki("b2b no gaps", got_cyc[47], got_cyc[0] + 47);
    end
    chki("b2b accept A", acc_cyc[0], 0);
    chki("b2b accept B", acc_cyc[1], 1);
    chki("b2b accept C", acc_cyc[2], 17);
    chk1("b2b blk_ready at A last", rdy16, 1'b0);
    chk1("b2b final busy", busy, 1'b0);

    // Reset mid-block with the hold buffer full
    blk_valid  = 1'b1;
    blk_data   = blocks[0];
    byte_ready = 1'b1;
    @(negedge clk);
    blk_data = blocks[1];
    @(negedge clk);
    blk_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk8("mid byte 6", byte_out, 8'h09);
    chk1("mid hold full", blk_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk1("mid rst byte_valid", byte_valid, 1'b0);
    chk1("mid rst busy", busy, 1'b0);
    chk1("mid rst blk_ready", blk_ready, 1'b0);
    chk8("mid rst byte_out", byte_out, 8'h00);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (byte_valid || busy) seen++;
    end
    chki("mid post-reset bytes", seen, 0);
    chk1("mid post-reset blk_ready", blk_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
